// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
package regfile_pkg;

    localparam int REG_W = 8;
    localparam int REG_A = 2;

    typedef logic [REG_A-1:0] reg_addr_t;
    typedef logic [REG_W-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: holds the last-granted index and
// produces a one-hot (or zero) grant each cycle.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_id_e last;

    // Grant selection: a lone request wins outright; on contention the
    // requester that did not win last time is chosen.
    always_comb begin
        grant = '0;
        if (!reset && !hold) begin
            if (req == 2'b11) begin
                grant = (last == REQ_MEM) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Pointer update: remember the index granted on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= REQ_MEM;
        end else if (grant[0]) begin
            last <= REQ_ALU;
        end else if (grant[1]) begin
            last <= REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the ALU
// writeback and the load-return path, and registers the winning write.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int W = REG_W,
    parameter int A = REG_A
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Hold,
    input  logic         Req0,
    input  logic [A-1:0] Waddr0,
    input  logic [W-1:0] Data0,
    input  logic         Req1,
    input  logic [A-1:0] Waddr1,
    input  logic [W-1:0] Data1,
    output logic         Grant0,
    output logic         Grant1,
    output logic         WriteEn,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         PendValid,
    output logic [A-1:0] PendAddr
);

    logic [1:0] grant;

    rr_arb2 u_arb (
        .clk   (Clk),
        .reset (Reset),
        .hold  (Hold),
        .req   ({Req1, Req0}),
        .grant (grant)
    );

    assign Grant0 = grant[0];
    assign Grant1 = grant[1];

    // Output stage: capture the granted write; address/data hold when idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            WriteEn <= 1'b0;
            Waddr   <= '0;
            DataIn  <= '0;
        end else if (grant[1]) begin
            WriteEn <= 1'b1;
            Waddr   <= Waddr1;
            DataIn  <= Data1;
        end else if (grant[0]) begin
            WriteEn <= 1'b1;
            Waddr   <= Waddr0;
            DataIn  <= Data0;
        end else begin
            WriteEn <= 1'b0;
        end
    end

    // The in-flight write is exactly the output-stage contents.
    assign PendValid = WriteEn;
    assign PendAddr  = Waddr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file
// model attached to the write port.
module tb_regfile_write_arbiter;

    logic       Clk = 1'b0;
    logic       Reset, Hold;
    logic       Req0, Req1;
    logic [1:0] Waddr0, Waddr1;
    logic [7:0] Data0, Data1;
    logic       Grant0, Grant1, WriteEn, PendValid;
    logic [1:0] Waddr, PendAddr;
    logic [7:0] DataIn;

    logic [7:0] rf [4];
    int         n_checks = 0;
    int         n_fail   = 0;

    regfile_write_arbiter #(.W(8), .A(2)) dut (
        .Clk(Clk), .Reset(Reset), .Hold(Hold),
        .Req0(Req0), .Waddr0(Waddr0), .Data0(Data0),
        .Req1(Req1), .Waddr1(Waddr1), .Data1(Data1),
        .Grant0(Grant0), .Grant1(Grant1),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .PendValid(PendValid), .PendAddr(PendAddr)
    );

    always #5 Clk = ~Clk;

    // Register file model: synchronous reset dominates the write.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else if (WriteEn) begin
            rf[Waddr] <= DataIn;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Hold = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
        Waddr0 = '0; Waddr1 = '0; Data0 = '0; Data1 = '0;
        tick(); tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Hold = 1'b0; Req0 = 1'b1; Req1 = 1'b1;
        Waddr0 = 2'd1; Data0 = 8'h11; Waddr1 = 2'd2; Data1 = 8'h22;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({Grant1, Grant0} !== 2'b00) begin
                n_fail++; $display("FAIL reset_grant c%0d got=%b exp=00", c, {Grant1, Grant0});
            end
            tick();
            n_checks++;
            if ({WriteEn, Waddr, DataIn} !== 11'd0) begin
                n_fail++; $display("FAIL reset_outputs c%0d got we=%b a=%0d d=%h exp 0/0/00",
                                   c, WriteEn, Waddr, DataIn);
            end
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_grant got=%b exp=01", {Grant1, Grant0});
        end
        tick();
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        Req0 = 1'b1; Waddr0 = 2'd2; Data0 = 8'hA5;
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b01) begin
            n_fail++; $display("FAIL single_grant got=%b exp=01", {Grant1, Grant0});
        end
        tick();
        Req0 = 1'b0;
        n_checks++;
        if ({WriteEn, Waddr, DataIn, PendValid, PendAddr} !== {1'b1, 2'd2, 8'hA5, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL single_write got we=%b a=%0d d=%h pv=%b pa=%0d exp 1/2/a5/1/2",
                               WriteEn, Waddr, DataIn, PendValid, PendAddr);
        end
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle_grant got=%b exp=00", {Grant1, Grant0});
        end
        tick();
        n_checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b0, 2'd2, 8'hA5}) begin
            n_fail++; $display("FAIL single_after got we=%b a=%0d d=%h exp 0/2/a5", WriteEn, Waddr, DataIn);
        end
        n_checks++;
        if (rf[2] !== 8'hA5) begin
            n_fail++; $display("FAIL single_rf got=%h exp=a5", rf[2]);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        logic [1:0] exp_a;
        logic [7:0] exp_d;
        do_reset();
        Req0 = 1'b1; Waddr0 = 2'd1; Data0 = 8'h11;
        Req1 = 1'b1; Waddr1 = 2'd3; Data1 = 8'h33;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 2'd1 : 2'd3;
            exp_d = (i % 2 == 0) ? 8'h11 : 8'h33;
            #1;
            n_checks++;
            if ({Grant1, Grant0} !== exp_g) begin
                n_fail++; $display("FAIL contention_grant i%0d got=%b exp=%b", i, {Grant1, Grant0}, exp_g);
            end
            tick();
            n_checks++;
            if ({WriteEn, Waddr, DataIn} !== {1'b1, exp_a, exp_d}) begin
                n_fail++; $display("FAIL contention_write i%0d got we=%b a=%0d d=%h exp 1/%0d/%h",
                                   i, WriteEn, Waddr, DataIn, exp_a, exp_d);
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();
        n_checks++;
        if (WriteEn !== 1'b0) begin
            n_fail++; $display("FAIL contention_end got we=%b exp=0", WriteEn);
        end
    endtask

    task automatic test_hold();
        do_reset();
        // One lone grant to requester 0 leaves requester 1 next in line.
        Req0 = 1'b1; Waddr0 = 2'd1; Data0 = 8'h11;
        tick();
        Req1 = 1'b1; Waddr1 = 2'd3; Data1 = 8'h33;
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({Grant1, Grant0} !== 2'b00) begin
                n_fail++; $display("FAIL hold_grant i%0d got=%b exp=00", i, {Grant1, Grant0});
            end
            tick();
            n_checks++;
            if (WriteEn !== 1'b0) begin
                n_fail++; $display("FAIL hold_we i%0d got=%b exp=0", i, WriteEn);
            end
        end
        Hold = 1'b0;
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b10) begin
            n_fail++; $display("FAIL hold_release_grant got=%b exp=10", {Grant1, Grant0});
        end
        tick();
        Req1 = 1'b0;
        n_checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 2'd3, 8'h33}) begin
            n_fail++; $display("FAIL hold_release_write got we=%b a=%0d d=%h exp 1/3/33", WriteEn, Waddr, DataIn);
        end
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b01) begin
            n_fail++; $display("FAIL hold_pending_req0 got=%b exp=01", {Grant1, Grant0});
        end
        tick();
        Req0 = 1'b0;
    endtask

    task automatic test_same_addr();
        do_reset();
        Req0 = 1'b1; Waddr0 = 2'd1; Data0 = 8'h0F;
        Req1 = 1'b1; Waddr1 = 2'd1; Data1 = 8'hF0;
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b01) begin
            n_fail++; $display("FAIL same_grant0 got=%b exp=01", {Grant1, Grant0});
        end
        tick();
        Req0 = 1'b0;
        n_checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 2'd1, 8'h0F}) begin
            n_fail++; $display("FAIL same_write0 got we=%b a=%0d d=%h exp 1/1/0f", WriteEn, Waddr, DataIn);
        end
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b10) begin
            n_fail++; $display("FAIL same_grant1 got=%b exp=10", {Grant1, Grant0});
        end
        tick();
        Req1 = 1'b0;
        n_checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 2'd1, 8'hF0}) begin
            n_fail++; $display("FAIL same_write1 got we=%b a=%0d d=%h exp 1/1/f0", WriteEn, Waddr, DataIn);
        end
        tick();
        n_checks++;
        if (rf[1] !== 8'hF0) begin
            n_fail++; $display("FAIL same_rf got=%h exp=f0", rf[1]);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        Req1 = 1'b1; Waddr1 = 2'd3; Data1 = 8'h77;
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b10) begin
            n_fail++; $display("FAIL mid_grant got=%b exp=10", {Grant1, Grant0});
        end
        tick();
        Req1 = 1'b0;
        Reset = 1'b1;
        Req0 = 1'b1; Waddr0 = 2'd0; Data0 = 8'h55;
        n_checks++;
        if (WriteEn !== 1'b1) begin
            n_fail++; $display("FAIL mid_pending got we=%b exp=1", WriteEn);
        end
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_grant got=%b exp=00", {Grant1, Grant0});
        end
        tick();
        Reset = 1'b0;
        n_checks++;
        if (WriteEn !== 1'b0 || rf[3] !== 8'h00) begin
            n_fail++; $display("FAIL mid_discard got we=%b rf3=%h exp 0/00", WriteEn, rf[3]);
        end
        #1;
        n_checks++;
        if ({Grant1, Grant0} !== 2'b01) begin
            n_fail++; $display("FAIL mid_after_grant got=%b exp=01", {Grant1, Grant0});
        end
        tick();
        Req0 = 1'b0;
        n_checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 2'd0, 8'h55}) begin
            n_fail++; $display("FAIL mid_addr0_write got we=%b a=%0d d=%h exp 1/0/55", WriteEn, Waddr, DataIn);
        end
        tick();
        n_checks++;
        if (rf[0] !== 8'h55 || rf[3] !== 8'h00) begin
            n_fail++; $display("FAIL mid_rf got rf0=%h rf3=%h exp 55/00", rf[0], rf[3]);
        end
    endtask

    initial begin
        Reset = 1'b1; Hold = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
        Waddr0 = '0; Waddr1 = '0; Data0 = '0; Data1 = '0;
        tick();
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_same_addr();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 4-entry, 8-bit register file between two requesters: requester 0 (ALU writeback) and requester 1 (data-memory load return).
- Round-robin arbitration with a request/grant handshake.
- The winning write goes into a one-entry output stage that drives WriteEn/Waddr/DataIn of the register file.
- The in-flight write is also exported so decode can forward it or stall on it.

Parameters:
- W, 8, data path width.
- A, 2, register address width (2**A registers).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
- Hold  input  1  pipeline stall; while high, no new grant is issued.
- Req0  input  1  requester 0 write request.
- Waddr0  input  A  requester 0 destination register.
- Data0  input  W  requester 0 write data.
- Req1  input  1  requester 1 write request.
- Waddr1  input  A  requester 1 destination register.
- Data1  input  W  requester 1 write data.
- Grant0  output  1  requester 0 write accepted this cycle (combinational).
- Grant1  output  1  requester 1 write accepted this cycle (combinational).
- WriteEn  output  1  register file write enable (registered).
- Waddr  output  A  register file write address (registered).
- DataIn  output  W  register file write data (registered).
- PendValid  output  1  a write is in the output stage (equals WriteEn).
- PendAddr  output  A  address of the pending write (equals Waddr).

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
  - Reset clears: WriteEn=0, Waddr=0, DataIn=0, round-robin pointer Last=1 (so requester 0 wins first).
  - Grant0/Grant1 are forced 0 during any cycle in which Reset is high.
- Handshake:
  - A requester holds Req, Waddr and Data stable until it sees its Grant high in the same cycle.
  - At that posedge the transfer completes. The requester may drop Req or present a new write the next cycle.
- Arbitration (combinational, per cycle, when Hold=0 and Reset=0):
  - Only Req0 high: Grant0=1.
  - Only Req1 high: Grant1=1.
  - Both high: grant the requester not equal to Last.
  - Neither high: no grant.
  - At most one Grant is ever high; the Grant signals are one-hot or zero.
- Pointer: Last is updated to the granted index on the posedge of any granted cycle. Otherwise it is unchanged.
- Output stage:
  - On a posedge with a grant: WriteEn<=1, Waddr<=granted addr, DataIn<=granted data.
  - On a posedge without a grant: WriteEn<=0. Waddr and DataIn hold their values.
  - Latency: Grant in cycle t gives WriteEn high in cycle t+1, and the register file updates at the end of t+1.
  - Throughput is one write per cycle; the output stage never back-pressures.
- Hold=1: both Grants are 0, Last is unchanged, WriteEn<=0 next cycle. Requests stay pending with no loss.
- Same-address contention: if Waddr0==Waddr1 with both requesting, arbitration is unchanged. The two writes occur in grant order, and the later-granted value is the final register content.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1... No requester waits more than 1 cycle while Hold=0.
- Reset mid-operation:
  - A pending output-stage write is discarded, so WriteEn=0 on the cycle after Reset.
  - A requester whose Req is high sees no Grant and must keep Req asserted after Reset falls.
- Register 0 gets no special treatment: writes to address 0 are legal.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams REG_W=8 and REG_A=2;
  - typedef reg_addr_t (logic [REG_A-1:0]);
  - typedef reg_data_t (logic [REG_W-1:0]);
  - typedef wr_req_t, a struct {valid, addr, data};
  - enum req_id_e {REQ_ALU=0, REQ_MEM=1}.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter holding the Last flop and producing the one-hot grant.
- The output-stage register lives in the top module.

Test Plan:
- Reset then idle: assert Reset 2 cycles with Req0=Req1=1 -> Grant0=Grant1=0 throughout, WriteEn=0, Waddr=0, DataIn=0; first grant after release goes to requester 0.
- Single requester: Req0=1, Waddr0=2, Data0=8'hA5 for 1 cycle -> Grant0=1 that cycle; next cycle WriteEn=1, Waddr=2, DataIn=8'hA5, PendValid=1, PendAddr=2; the cycle after, WriteEn=0.
- Contention alternation: Req0=Req1=1 for 4 cycles (Waddr0=1/Data0=8'h11, Waddr1=3/Data1=8'h33) -> grants 0,1,0,1; WriteEn=1 for 4 consecutive cycles with Waddr sequence 1,3,1,3.
- Hold: both requesting, Hold=1 for 3 cycles -> no grants, WriteEn=0, Last unchanged; Hold drops -> grant goes to the requester that would have won before Hold.
- Same address: Req0 (addr 1, 8'h0F) and Req1 (addr 1, 8'hF0) together, Last=1 -> writes 8'h0F then 8'hF0; register file reg1 ends at 8'hF0.
- Reset mid-flight: grant Req1 (addr 3, 8'h77), assert Reset the next cycle -> WriteEn=0 after the Reset edge, and register file reg3 stays at 8'h00.
